// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the forwarding / load-use hazard unit:
// forward-select encodings, default register address width, stall counter width.
package hazard_forward_unit_pkg;

    typedef enum logic [2:0] {
        FWD_RF  = 3'd0,
        FWD_EX  = 3'd1,
        FWD_MEM = 3'd2,
        FWD_WB  = 3'd3,
        FWD_S4  = 3'd4
    } fwd_src_e;

    localparam int REG_AW_DEF  = 5;
    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/hazard_forward_unit_track.sv
// One entry of the destination-register tracking pipeline.
// Loads the upstream record when accept=1, otherwise captures a bubble.
module hazard_track_stage
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              accept,
    input  logic [REG_AW-1:0] nxt_rw,
    input  logic              nxt_regwrite,
    input  logic              nxt_memread,
    output logic [REG_AW-1:0] rw,
    output logic              regwrite,
    output logic              memread
);

    always_ff @(posedge clk) begin
        if (rst || !accept) begin
            rw       <= '0;
            regwrite <= 1'b0;
            memread  <= 1'b0;
        end else begin
            rw       <= nxt_rw;
            regwrite <= nxt_regwrite;
            memread  <= nxt_memread;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding select and load-use stall generation from a self-maintained record
// of in-flight destination registers; also counts stall cycles (saturating).
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_AW     = REG_AW_DEF,
    parameter int NUM_SRC    = 2,
    parameter int FWD_STAGES = 2,
    parameter int LOAD_LAT   = 2,
    parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_rw,
    input  logic                      id_regwrite,
    input  logic                      id_memread,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
    output logic [STALL_CNT_W-1:0]    stall_count
);

    logic [REG_AW-1:0] s_rw       [1:FWD_STAGES];
    logic              s_regwrite [1:FWD_STAGES];
    logic              s_memread  [1:FWD_STAGES];

    logic              issue;
    logic              load_hit;
    logic [REG_AW-1:0] src;
    logic [SEL_W-1:0]  sel;

    assign issue = id_valid & ~stall & ~flush;

    for (genvar k = 1; k <= FWD_STAGES; k++) begin : g_stage
        if (k == 1) begin : g_head
            hazard_track_stage #(.REG_AW(REG_AW)) u_stage (
                .clk          (clk),
                .rst          (rst),
                .accept       (issue),
                .nxt_rw       (id_rw),
                .nxt_regwrite (id_regwrite),
                .nxt_memread  (id_memread),
                .rw           (s_rw[k]),
                .regwrite     (s_regwrite[k]),
                .memread      (s_memread[k])
            );
        end else begin : g_tail
            // Older entries always drain, even while ID is stalled.
            hazard_track_stage #(.REG_AW(REG_AW)) u_stage (
                .clk          (clk),
                .rst          (rst),
                .accept       (1'b1),
                .nxt_rw       (s_rw[k-1]),
                .nxt_regwrite (s_regwrite[k-1]),
                .nxt_memread  (s_memread[k-1]),
                .rw           (s_rw[k]),
                .regwrite     (s_regwrite[k]),
                .memread      (s_memread[k])
            );
        end
    end

    // Scan oldest to youngest so the youngest matching producer is left in sel.
    always_comb begin
        load_hit = 1'b0;
        fwd_sel  = '0;
        src      = '0;
        sel      = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src = id_src[i*REG_AW +: REG_AW];
            sel = SEL_W'(FWD_RF);
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (id_src_used[i] && s_regwrite[k] && (s_rw[k] != '0) && (s_rw[k] == src)) begin
                    sel = SEL_W'(k);
                    if ((k < LOAD_LAT) && s_memread[k]) begin
                        load_hit = 1'b1;
                    end
                end
            end
            fwd_sel[i*SEL_W +: SEL_W] = sel;
        end
    end

    assign stall = load_hit & id_valid & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (stall && (stall_count != '1)) begin
            stall_count <= stall_count + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Self-checking bench: directed scenarios plus random traffic, checked every cycle
// against an issue-history model for a default and a 3-stage/late-load instance.
module tb_hazard_forward_unit;

    typedef struct packed {
        logic [4:0] rw;
        logic       wr;
        logic       ld;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [9:0]  id_src = '0;
    logic [1:0]  id_src_used = '0;
    logic [4:0]  id_rw = '0;
    logic        id_regwrite = 1'b0;
    logic        id_memread = 1'b0;
    logic        flush = 1'b0;

    logic        stall0, stall1;
    logic [3:0]  sel0, sel1;
    logic [15:0] cnt0, cnt1;

    ent_t        h0 [1:4];
    ent_t        h1 [1:4];
    logic [15:0] mc0, mc1;
    bit          mvalid = 1'b0;
    bit          st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_forward_unit u0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rw(id_rw), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .stall(stall0),
        .fwd_sel(sel0), .stall_count(cnt0)
    );

    hazard_forward_unit #(.FWD_STAGES(3), .LOAD_LAT(3)) u1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src(id_src),
        .id_src_used(id_src_used), .id_rw(id_rw), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .flush(flush), .stall(stall1),
        .fwd_sel(sel1), .stall_count(cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input ent_t e, input int i);
        logic [4:0] s;
        s = id_src[i*5 +: 5];
        return e.wr && (e.rw != 5'd0) && (e.rw == s) && id_src_used[i];
    endfunction

    // Youngest (lowest-numbered) producer among the first fs issues wins.
    function automatic logic [3:0] model_sel(input ent_t h [1:4], input int fs);
        logic [3:0] r;
        int best;
        r = '0;
        for (int i = 0; i < 2; i++) begin
            best = 0;
            for (int k = 1; k <= fs; k++)
                if (best == 0 && hit(h[k], i)) best = k;
            r[i*2 +: 2] = 2'(best);
        end
        return r;
    endfunction

    function automatic bit model_stall(input ent_t h [1:4], input int ll);
        if (flush || !id_valid) return 1'b0;
        for (int i = 0; i < 2; i++)
            for (int k = 1; k < ll; k++)
                if (hit(h[k], i) && h[k].ld) return 1'b1;
        return 1'b0;
    endfunction

    // Model update on each rising edge.
    initial forever begin
        @(posedge clk);
        if (rst) begin
            for (int k = 1; k <= 4; k++) begin
                h0[k] = '0;
                h1[k] = '0;
            end
            mc0 = '0;
            mc1 = '0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            st0 = model_stall(h0, 2);
            st1 = model_stall(h1, 3);
            if (st0 && mc0 != 16'hFFFF) mc0 = mc0 + 16'd1;
            if (st1 && mc1 != 16'hFFFF) mc1 = mc1 + 16'd1;
            for (int k = 4; k >= 2; k--) begin
                h0[k] = h0[k-1];
                h1[k] = h1[k-1];
            end
            h0[1] = (id_valid && !flush && !st0) ? ent_t'({id_rw, id_regwrite, id_memread}) : ent_t'(0);
            h1[1] = (id_valid && !flush && !st1) ? ent_t'({id_rw, id_regwrite, id_memread}) : ent_t'(0);
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (mvalid) begin
            check("stall_u0", 32'(stall0), 32'(model_stall(h0, 2)));
            check("stall_u1", 32'(stall1), 32'(model_stall(h1, 3)));
            if (!stall0) check("fwd_sel_u0", 32'(sel0), 32'(model_sel(h0, 2)));
            if (!stall1) check("fwd_sel_u1", 32'(sel1), 32'(model_sel(h1, 3)));
            check("count_u0", 32'(cnt0), 32'(mc0));
            check("count_u1", 32'(cnt1), 32'(mc1));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rw, input logic wr, input logic ld,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                         input logic fl);
        id_valid    = v;
        id_rw       = rw;
        id_regwrite = wr;
        id_memread  = ld;
        id_src      = {s1, s0};
        id_src_used = used;
        flush       = fl;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        repeat (n) cyc();
    endtask

    task automatic load_use_pair();
        drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01, 1'b0);
        cyc();
        cyc();
        idle(3);
    endtask

    initial begin
        // reset, then idle
        repeat (2) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("reset_stall", 32'(stall0), 32'd0);
        check("reset_sel", 32'(sel0), 32'd0);
        check("reset_count", 32'(cnt0), 32'd0);
        cyc();

        // EX copy beats MEM copy
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 5'd3, 1'b1, 1'b0, 5'd1, 5'd2, 2'b11, 1'b0);
        cyc();
        drive(1'b1, 5'd9, 1'b1, 1'b0, 5'd3, 5'd3, 2'b11, 1'b0);
        @(negedge clk);
        check("exmem_sel", 32'(sel0), 32'h5);
        check("exmem_stall", 32'(stall0), 32'd0);
        cyc();
        idle(4);

        // load-use: exactly one stall, then MEM forward
        drive(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 5'd0, 2'b01, 1'b0);
        @(negedge clk);
        check("lu_stall_1", 32'(stall0), 32'd1);
        cyc();
        @(negedge clk);
        check("lu_stall_2", 32'(stall0), 32'd0);
        check("lu_sel", 32'(sel0[1:0]), 32'd2);
        check("lu_count", 32'(cnt0), 32'd1);
        cyc();
        idle(4);

        // r0 is never forwarded
        drive(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd0, 5'd0, 2'b01, 1'b0);
        @(negedge clk);
        check("r0_sel", 32'(sel0), 32'd0);
        check("r0_stall", 32'(stall0), 32'd0);
        cyc();
        idle(3);

        // unused operand ignored
        drive(1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 5'd4, 1'b1, 1'b0, 5'd1, 5'd7, 2'b01, 1'b0);
        @(negedge clk);
        check("unused_sel", 32'(sel0), 32'd0);
        check("unused_stall", 32'(stall0), 32'd0);
        cyc();
        idle(4);

        // flush beats the would-be stall and bubbles stage 1
        drive(1'b1, 5'd2, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd2, 5'd0, 2'b01, 1'b1);
        @(negedge clk);
        check("flush_stall", 32'(stall0), 32'd0);
        cyc();
        drive(1'b1, 5'd8, 1'b1, 1'b0, 5'd2, 5'd0, 2'b01, 1'b0);
        @(negedge clk);
        check("flush_bubble_sel", 32'(sel0[1:0]), 32'd2);
        check("flush_bubble_stall", 32'(stall0), 32'd0);
        check("flush_count", 32'(cnt0), 32'd1);
        cyc();
        idle(5);

        // FWD_STAGES=3, LOAD_LAT=3: two stall cycles then WB forward
        drive(1'b1, 5'd4, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 1'b0);
        cyc();
        drive(1'b1, 5'd10, 1'b1, 1'b0, 5'd4, 5'd0, 2'b01, 1'b0);
        @(negedge clk);
        check("v3_stall_1", 32'(stall1), 32'd1);
        cyc();
        @(negedge clk);
        check("v3_stall_2", 32'(stall1), 32'd1);
        cyc();
        @(negedge clk);
        check("v3_stall_3", 32'(stall1), 32'd0);
        check("v3_sel", 32'(sel1[1:0]), 32'd3);
        cyc();
        idle(5);

        // saturation: preload near the top, then keep stalling
        force u0.stall_count = 16'hFFFD;
        mc0 = 16'hFFFD;
        #1;
        release u0.stall_count;
        repeat (3) load_use_pair();
        @(negedge clk);
        check("sat_count", 32'(cnt0), 32'hFFFF);
        cyc();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 99) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_src      = {2'b00, 3'($urandom_range(0, 7)), 2'b00, 3'($urandom_range(0, 7))};
            id_src_used = 2'($urandom_range(0, 3));
            id_rw       = 5'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_memread  = ($urandom_range(0, 4) < 2);
            flush       = ($urandom_range(0, 9) == 0);
            cyc();
        end
        rst = 1'b0;
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
